pixel_pack: RTL and testbench
=============================

Name: pixel_pack

Overview:
- Upstream neighbour of the frame-memory write stage.
- Takes the deserialised sensor stream (4 × 8-bit pixels per pclock, gated by frame_valid/line_valid) and packs two beats into one 64-bit word.
- Produces the record / end_line / end_frame / data strobes that the write stage consumes.
- Checks line and frame geometry and flags violations with sticky error bits.

Parameters:
- WORDS_PER_LINE, 240, 64-bit words expected per line (1920 pixels).
- LINES_PER_FRAME, 1920, lines expected per frame.

Ports:
- pclock  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- frame_valid  in  1  high for the duration of a frame.
- line_valid  in  1  high while pixel beats of a line are present.
- pix_in  in  32  four pixels; pixel 0 in [7:0], pixel 3 in [31:24].
- record  out  1  one-cycle strobe; data_out holds a valid word.
- end_line  out  1  one-cycle pulse after each completed line.
- end_frame  out  1  one-cycle pulse at the end of a frame.
- data_out  out  64  packed word; earlier beat in [31:0], later beat in [63:32].
- line_err  out  1  sticky; set on a bad line length or odd beat count.
- frame_err  out  1  sticky; set on a bad line count.

Behaviour:
- Reset:
  - record, end_line, end_frame, data_out, line_err and frame_err all go to 0.
  - State goes to ARM. Counters and the beat phase clear. Any partially held beat is discarded.
  - Reset has priority over everything, including mid-line.
- State machine:
  - ARM: waits for frame_valid to be sampled low, then goes to IDLE. This prevents starting mid-frame after reset.
  - IDLE: frame_valid sampled high → FRAME; line_cnt and phase clear.
  - FRAME: line_valid sampled high → LINE; word_cnt clears and this beat is taken as phase 0.
  - LINE, per cycle with line_valid high:
    - Phase 0: store pix_in into hold[31:0]; phase becomes 1.
    - Phase 1: data_out <= {pix_in, hold}; record = 1 on the next cycle; word_cnt increments; phase becomes 0.
  - LINE, line_valid sampled low (line end):
    - end_line = 1 on the next cycle. line_cnt increments, saturating at 2047. Go to FRAME.
    - line_err is set if phase = 1 (the partial beat is dropped, no record) or if word_cnt ≠ WORDS_PER_LINE.
  - frame_valid sampled low in FRAME or LINE:
    - end_frame = 1 on the next cycle. Go to IDLE.
    - If in LINE: the line is closed with the same length/phase checks as above, line_cnt increments, and **no end_line is pulsed** (end_frame alone resets the downstream row counter).
    - frame_err is set if the final line_cnt ≠ LINES_PER_FRAME.
- Latency:
  - record asserts 1 cycle after the second beat is sampled.
  - end_line and end_frame assert 1 cycle after the falling valid is sampled.
  - record therefore never coincides with end_line or end_frame for the same line.
- Widths:
  - word_cnt is 8-bit, saturating at 255, so an over-long line still errors rather than wrapping to a matching count.
  - line_cnt is 11-bit, saturating.
- Ignored inputs:
  - line_valid while in ARM or IDLE.
  - pix_in while line_valid is low.
- data_out holds its last value when record = 0.
- Back-to-back lines: a single low cycle of line_valid between lines is legal. end_line is pulsed and the new line starts on the next high sample.
- Errors clear only on reset.

Test Plan:
- Reset, hold frame_valid low, then 1920 lines of 480 beats each, beat k = {4 bytes of k[7:0]}, 1-cycle gaps:
  - 240 records per line, the first word = 0x01010101_00000000.
  - 1919 end_line pulses (the final line is closed by frame_valid falling, with no end_line).
  - 1 end_frame pulse; no errors.
- Line of 479 beats: 239 records, last beat dropped, line_err = 1 and stays 1 through the next frame.
- Line of 482 beats: word_cnt 241 ≠ 240 → line_err = 1; 241 records are still emitted.
- frame_valid falls while line_valid is high: end_frame pulses once, no end_line on that cycle or the next, and record never coincides with either strobe. A frame of 1919 lines gives frame_err = 1.
- Mid-frame and mid-line starts:
  - Reset asserted mid-line: outputs go to 0 the next cycle. A frame already in progress at reset release is ignored (no record) until frame_valid goes low, then high again.
  - Release reset while frame_valid is high: no record until frame_valid has toggled low then high.

Source files
------------

// File: rtl/pixel_pack.sv
`default_nettype none
// ============================================================================
//  pixel_pack : packs pairs of 32-bit sensor beats into 64-bit words, emits
//               record/end_line/end_frame strobes, flags geometry errors.
//  Rev 1.0
// ============================================================================
module pixel_pack #(
  parameter int WORDS_PER_LINE  = 240,
  parameter int LINES_PER_FRAME = 1920
) (
  input  logic        pclock,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic [31:0] pix_in,
  output logic        record,
  output logic        end_line,
  output logic        end_frame,
  output logic [63:0] data_out,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [7:0]  C_WPL = 8'(WORDS_PER_LINE);
  localparam logic [10:0] C_LPF = 11'(LINES_PER_FRAME);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2,
    LINE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic        record_q, record_d;
  logic        end_line_q, end_line_d;
  logic        end_frame_q, end_frame_d;
  logic [63:0] data_q, data_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;

  logic [10:0] line_cnt_inc;
  logic        line_bad;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hold_d       = hold_q;
    word_cnt_d   = word_cnt_q;
    line_cnt_d   = line_cnt_q;
    record_d     = 1'b0;
    end_line_d   = 1'b0;
    end_frame_d  = 1'b0;
    data_d       = data_q;
    line_err_d   = line_err_q;
    frame_err_d  = frame_err_q;

    line_cnt_inc = (line_cnt_q == 11'h7FF) ? line_cnt_q : line_cnt_q + 11'd1;
    line_bad     = phase_q || (word_cnt_q != C_WPL);

    case (state_q)
      ARM: begin
        // Only arm once a frame boundary has been seen, never mid-frame
        if (!frame_valid) state_d = IDLE;
      end
      IDLE: begin
        if (frame_valid) begin
          state_d    = FRAME;
          line_cnt_d = 11'd0;
          phase_d    = 1'b0;
        end
      end
      FRAME: begin
        if (!frame_valid) begin
          end_frame_d = 1'b1;
          state_d     = IDLE;
          if (line_cnt_q != C_LPF) frame_err_d = 1'b1;
        end else if (line_valid) begin
          state_d    = LINE;
          word_cnt_d = 8'd0;
          hold_d     = pix_in;
          phase_d    = 1'b1;
        end
      end
      LINE: begin
        if (!frame_valid || !line_valid) begin
          // Line closes; a dangling half-word is dropped and counts as an error
          line_cnt_d = line_cnt_inc;
          phase_d    = 1'b0;
          if (line_bad) line_err_d = 1'b1;
          if (!frame_valid) begin
            end_frame_d = 1'b1;
            state_d     = IDLE;
            if (line_cnt_inc != C_LPF) frame_err_d = 1'b1;
          end else begin
            end_line_d = 1'b1;
            state_d    = FRAME;
          end
        end else if (!phase_q) begin
          hold_d  = pix_in;
          phase_d = 1'b1;
        end else begin
          data_d     = {pix_in, hold_q};
          record_d   = 1'b1;
          phase_d    = 1'b0;
          word_cnt_d = (word_cnt_q == 8'hFF) ? word_cnt_q : word_cnt_q + 8'd1;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge pclock) begin
    if (reset) begin
      state_q     <= ARM;
      phase_q     <= 1'b0;
      hold_q      <= 32'd0;
      word_cnt_q  <= 8'd0;
      line_cnt_q  <= 11'd0;
      record_q    <= 1'b0;
      end_line_q  <= 1'b0;
      end_frame_q <= 1'b0;
      data_q      <= 64'd0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      word_cnt_q  <= word_cnt_d;
      line_cnt_q  <= line_cnt_d;
      record_q    <= record_d;
      end_line_q  <= end_line_d;
      end_frame_q <= end_frame_d;
      data_q      <= data_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign record    = record_q;
  assign end_line  = end_line_q;
  assign end_frame = end_frame_q;
  assign data_out  = data_q;
  assign line_err  = line_err_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_pack.sv
`default_nettype none
// ============================================================================
//  tb_pixel_pack : directed tests for pixel_pack with a reduced geometry of
//                  4 words (8 beats) per line and 3 lines per frame.
//  Rev 1.0
// ============================================================================
module tb_pixel_pack;

  logic        pclock;
  logic        reset;
  logic        frame_valid;
  logic        line_valid;
  logic [31:0] pix_in;
  logic        record;
  logic        end_line;
  logic        end_frame;
  logic [63:0] data_out;
  logic        line_err;
  logic        frame_err;

  int tests;
  int fails;
  int rec_cnt;
  int el_cnt;
  int ef_cnt;
  int overlap_cnt;
  bit got_first;
  logic [63:0] first_word;
  logic [63:0] last_word;

  pixel_pack #(
    .WORDS_PER_LINE (4),
    .LINES_PER_FRAME(3)
  ) dut (
    .pclock     (pclock),
    .reset      (reset),
    .frame_valid(frame_valid),
    .line_valid (line_valid),
    .pix_in     (pix_in),
    .record     (record),
    .end_line   (end_line),
    .end_frame  (end_frame),
    .data_out   (data_out),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  task automatic clear_counts();
    rec_cnt     = 0;
    el_cnt      = 0;
    ef_cnt      = 0;
    overlap_cnt = 0;
    got_first   = 1'b0;
    first_word  = '0;
    last_word   = '0;
  endtask

  // Advance one cycle; outputs are observed on the falling edge
  task automatic step();
    @(negedge pclock);
    if (record) begin
      rec_cnt++;
      if (!got_first) begin
        first_word = data_out;
        got_first  = 1'b1;
      end
      last_word = data_out;
    end
    if (end_line)  el_cnt++;
    if (end_frame) ef_cnt++;
    if (record && (end_line || end_frame)) overlap_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_valid = 1'b0; line_valid = 1'b0; pix_in = '0;
    step(); step();
    reset = 1'b0;
    step();
    clear_counts();
  endtask

  task automatic send_beats(input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = k[7:0];
      pix_in     = {4{b}};
      line_valid = 1'b1;
      step();
    end
  endtask

  // Full frame; line odd_line carries odd_beats beats, the others 8.
  // The last line is closed by frame_valid falling together with line_valid.
  task automatic run_frame(input int nlines, input int odd_line, input int odd_beats);
    frame_valid = 1'b1;
    step();
    for (int i = 0; i < nlines; i++) begin
      send_beats((i == odd_line) ? odd_beats : 8);
      line_valid = 1'b0;
      pix_in     = '0;
      if (i == nlines - 1) frame_valid = 1'b0;
      step();
    end
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_valid = 1'b0; line_valid = 1'b0; pix_in = '0;
    step(); step();
    tests++; if (record !== 1'b0)    begin fails++; $display("FAIL reset_record: got %b expected 0", record); end
    tests++; if (end_line !== 1'b0)  begin fails++; $display("FAIL reset_end_line: got %b expected 0", end_line); end
    tests++; if (end_frame !== 1'b0) begin fails++; $display("FAIL reset_end_frame: got %b expected 0", end_frame); end
    tests++; if (data_out !== 64'd0) begin fails++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    tests++; if (line_err !== 1'b0)  begin fails++; $display("FAIL reset_line_err: got %b expected 0", line_err); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_good_frame();
    do_reset();
    run_frame(3, -1, 8);
    tests++; if (rec_cnt !== 12) begin fails++; $display("FAIL good_records: got %0d expected 12", rec_cnt); end
    tests++; if (el_cnt !== 2)   begin fails++; $display("FAIL good_end_line: got %0d expected 2", el_cnt); end
    tests++; if (ef_cnt !== 1)   begin fails++; $display("FAIL good_end_frame: got %0d expected 1", ef_cnt); end
    tests++; if (first_word !== 64'h01010101_00000000) begin fails++; $display("FAIL good_first_word: got %h expected 0101010100000000", first_word); end
    tests++; if (last_word !== 64'h07070707_06060606)  begin fails++; $display("FAIL good_last_word: got %h expected 0707070706060606", last_word); end
    tests++; if (data_out !== 64'h07070707_06060606)   begin fails++; $display("FAIL good_data_hold: got %h expected 0707070706060606", data_out); end
    tests++; if (line_err !== 1'b0)  begin fails++; $display("FAIL good_line_err: got %b expected 0", line_err); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL good_frame_err: got %b expected 0", frame_err); end
    tests++; if (overlap_cnt !== 0)  begin fails++; $display("FAIL good_overlap: got %0d expected 0", overlap_cnt); end
  endtask

  task automatic test_short_line();
    do_reset();
    run_frame(3, 1, 7);
    tests++; if (rec_cnt !== 11)    begin fails++; $display("FAIL short_records: got %0d expected 11", rec_cnt); end
    tests++; if (line_err !== 1'b1) begin fails++; $display("FAIL short_line_err: got %b expected 1", line_err); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL short_frame_err: got %b expected 0", frame_err); end
    clear_counts();
    run_frame(3, -1, 8);
    tests++; if (rec_cnt !== 12)    begin fails++; $display("FAIL short_next_records: got %0d expected 12", rec_cnt); end
    tests++; if (line_err !== 1'b1) begin fails++; $display("FAIL short_sticky_line_err: got %b expected 1", line_err); end
  endtask

  task automatic test_long_line();
    do_reset();
    run_frame(3, 1, 10);
    tests++; if (rec_cnt !== 13)    begin fails++; $display("FAIL long_records: got %0d expected 13", rec_cnt); end
    tests++; if (el_cnt !== 2)      begin fails++; $display("FAIL long_end_line: got %0d expected 2", el_cnt); end
    tests++; if (line_err !== 1'b1) begin fails++; $display("FAIL long_line_err: got %b expected 1", line_err); end
  endtask

  task automatic test_frame_fall_mid_line();
    do_reset();
    frame_valid = 1'b1;
    step();
    send_beats(8);
    line_valid = 1'b0;
    step();
    send_beats(8);
    frame_valid = 1'b0;
    step();
    line_valid = 1'b0;
    step(); step();
    tests++; if (rec_cnt !== 8)      begin fails++; $display("FAIL fall_records: got %0d expected 8", rec_cnt); end
    tests++; if (el_cnt !== 1)       begin fails++; $display("FAIL fall_end_line: got %0d expected 1", el_cnt); end
    tests++; if (ef_cnt !== 1)       begin fails++; $display("FAIL fall_end_frame: got %0d expected 1", ef_cnt); end
    tests++; if (overlap_cnt !== 0)  begin fails++; $display("FAIL fall_overlap: got %0d expected 0", overlap_cnt); end
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL fall_frame_err: got %b expected 1", frame_err); end
    tests++; if (line_err !== 1'b0)  begin fails++; $display("FAIL fall_line_err: got %b expected 0", line_err); end
  endtask

  task automatic test_reset_mid_line();
    do_reset();
    frame_valid = 1'b1;
    step();
    send_beats(3);
    reset = 1'b1;
    step();
    tests++; if (record !== 1'b0)    begin fails++; $display("FAIL midrst_record: got %b expected 0", record); end
    tests++; if (data_out !== 64'd0) begin fails++; $display("FAIL midrst_data_out: got %h expected 0", data_out); end
    reset = 1'b0;
    clear_counts();
    send_beats(8);
    line_valid = 1'b0;
    step();
    send_beats(8);
    line_valid = 1'b0;
    step();
    tests++; if (rec_cnt !== 0) begin fails++; $display("FAIL midrst_no_record: got %0d expected 0", rec_cnt); end
    tests++; if (el_cnt !== 0)  begin fails++; $display("FAIL midrst_no_end_line: got %0d expected 0", el_cnt); end
    frame_valid = 1'b0;
    step();
    run_frame(3, -1, 8);
    tests++; if (rec_cnt !== 12)     begin fails++; $display("FAIL midrst_records: got %0d expected 12", rec_cnt); end
    tests++; if (ef_cnt !== 1)       begin fails++; $display("FAIL midrst_end_frame: got %0d expected 1", ef_cnt); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1; frame_valid = 1'b0; line_valid = 1'b0; pix_in = '0;
    clear_counts();
    test_reset();
    test_good_frame();
    test_short_line();
    test_long_line();
    test_frame_fall_mid_line();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
